sblk_row_sched: RTL and testbench

// Row-level scheduler in front of N_ROW superblocks. Takes one masked instruction stream and one masked

---
 rtl/sblk_row_sched_if.sv | 36 +++
 rtl/sblk_row_sched.sv | 109 ++++++++++
 tb/tb_sblk_row_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sblk_row_sched_if.sv
// sblk_row_sched_if: controller-facing and sblk-facing signal bundle of the row scheduler
interface sblk_row_sched_if #(
  parameter int N_ROW     = 3,
  parameter int WID_INST  = 14,
  parameter int WID_ACT   = 16,
  parameter int ACT_LANES = 2
);
  logic [WID_INST-1:0]                inst_in_data;
  logic [N_ROW-1:0]                   inst_in_mask;
  logic                               inst_in_vld;
  logic                               inst_in_rdy;
  logic [WID_INST*N_ROW-1:0]          inst_data;
  logic [N_ROW-1:0]                   inst_en;
  logic [N_ROW-1:0]                   status_sblk;
  logic [ACT_LANES*WID_ACT-1:0]       act_in_data;
  logic [N_ROW-1:0]                   act_in_mask;
  logic                               act_in_vld;
  logic                               act_in_rdy;
  logic [ACT_LANES*WID_ACT*N_ROW-1:0] act_data_out;
  logic [N_ROW-1:0]                   act_data_out_vld;
  logic [N_ROW-1:0]                   act_data_in_req;
  logic [N_ROW-1:0]                   row_busy;
  logic                               all_idle;
  modport master (
    output inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
           act_in_data, act_in_mask, act_in_vld, act_data_in_req,
    input  inst_in_rdy, inst_data, inst_en, act_in_rdy, act_data_out,
           act_data_out_vld, row_busy, all_idle
  );
  modport slave (
    input  inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
           act_in_data, act_in_mask, act_in_vld, act_data_in_req,
    output inst_in_rdy, inst_data, inst_en, act_in_rdy, act_data_out,
           act_data_out_vld, row_busy, all_idle
  );
endinterface

// File: rtl/sblk_row_sched.sv
// sblk_row_sched: fans masked inst/act streams out to N_ROW sblk rows via per-row FIFO and issue FSM.
// Optional ROW_PERF_CNT_EN adds perf_clr and per-row WAIT_DONE cycle counters perf_busy_cnt.
module sblk_row_sched #(
  parameter int N_ROW           = 3,
  parameter int WID_INST        = 14,
  parameter int INST_FIFO_DEPTH = 4,
  parameter int WID_ACT         = 16,
  parameter int ACT_LANES       = 2,
  parameter int BUSY_TIMEOUT    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ROW_PERF_CNT_EN
  input  logic                 perf_clr,
  output logic [32*N_ROW-1:0]  perf_busy_cnt,
`endif
  sblk_row_sched_if.slave      bus
);
  localparam int AW = $clog2(INST_FIFO_DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int AB = ACT_LANES * WID_ACT;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} st_t;
  st_t                 st [N_ROW];
  logic [WID_INST-1:0] mem [N_ROW][INST_FIFO_DEPTH];
  logic [AW-1:0]       wp [N_ROW];
  logic [AW-1:0]       rp [N_ROW];
  logic [AW:0]         cnt [N_ROW];
  logic [AW:0]         cnt_nxt [N_ROW];
  logic [TW-1:0]       tmo [N_ROW];
  logic [WID_INST-1:0] idata [N_ROW];
  logic [AB-1:0]       adat [N_ROW];
  logic                ien [N_ROW];
  logic                adv [N_ROW];
  logic [N_ROW-1:0]    full, push, pop, idle_nxt, busy_nxt;
  logic                inst_acc, act_acc;
  assign bus.inst_in_rdy = &(~bus.inst_in_mask | ~full);
  assign bus.act_in_rdy  = &(~bus.act_in_mask | bus.act_data_in_req);
  assign inst_acc = bus.inst_in_vld && bus.inst_in_rdy;
  assign act_acc  = bus.act_in_vld && bus.act_in_rdy;
  assign push     = inst_acc ? bus.inst_in_mask : '0;
  // Pop happens on the IDLE->ISSUE edge so the head is captured into inst_data there.
  always_comb begin
    for (int r = 0; r < N_ROW; r++) begin
      full[r]     = cnt[r] == (AW+1)'(INST_FIFO_DEPTH);
      pop[r]      = st[r] == IDLE && cnt[r] != '0 && !bus.status_sblk[r];
      cnt_nxt[r]  = cnt[r] + (AW+1)'(push[r]) - (AW+1)'(pop[r]);
      idle_nxt[r] = st[r] == IDLE      ? !pop[r] :
                    st[r] == WAIT_BUSY ? !bus.status_sblk[r] && tmo[r] == TW'(BUSY_TIMEOUT - 1) :
                    st[r] == WAIT_DONE && !bus.status_sblk[r];
      busy_nxt[r] = !idle_nxt[r] || cnt_nxt[r] != '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.row_busy <= '0;
      bus.all_idle <= 1'b1;
    end else begin
      bus.row_busy <= busy_nxt;
      bus.all_idle <= ~|busy_nxt;
    end
  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    assign bus.inst_data[r*WID_INST+:WID_INST] = idata[r];
    assign bus.inst_en[r]                      = ien[r];
    assign bus.act_data_out[r*AB+:AB]          = adat[r];
    assign bus.act_data_out_vld[r]             = adv[r];
    always_ff @(posedge clk)
      if (push[r]) mem[r][wp[r]] <= bus.inst_in_data;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st[r]    <= IDLE;
        wp[r]    <= '0;
        rp[r]    <= '0;
        cnt[r]   <= '0;
        tmo[r]   <= '0;
        ien[r]   <= 1'b0;
        idata[r] <= '0;
        adv[r]   <= 1'b0;
        adat[r]  <= '0;
      end else begin
        if (push[r]) wp[r] <= wp[r] + AW'(1);
        if (pop[r]) rp[r] <= rp[r] + AW'(1);
        if (pop[r]) idata[r] <= mem[r][rp[r]];
        cnt[r] <= cnt_nxt[r];
        ien[r] <= pop[r];
        case (st[r])
          IDLE:      if (pop[r]) st[r] <= ISSUE;
          ISSUE: begin
            st[r]  <= WAIT_BUSY;
            tmo[r] <= '0;
          end
          WAIT_BUSY:
            if (bus.status_sblk[r]) st[r] <= WAIT_DONE;
            else if (tmo[r] == TW'(BUSY_TIMEOUT - 1)) st[r] <= IDLE;
            else tmo[r] <= tmo[r] + TW'(1);
          default:   if (!bus.status_sblk[r]) st[r] <= IDLE;
        endcase
        adv[r] <= act_acc && bus.act_in_mask[r];
        if (act_acc && bus.act_in_mask[r]) adat[r] <= bus.act_in_data;
      end
`ifdef ROW_PERF_CNT_EN
    logic [31:0] pc;
    assign perf_busy_cnt[r*32+:32] = pc;
    always_ff @(posedge clk or posedge rst)
      if (rst) pc <= '0;
      else if (perf_clr) pc <= '0;
      else if (st[r] == WAIT_DONE && pc != '1) pc <= pc + 32'd1;
`endif
  end
endmodule

// File: tb/tb_sblk_row_sched.sv
// tb_sblk_row_sched: directed stimulus, queue-based reference model compared every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_sblk_row_sched;
  localparam int NR = 3, WI = 14, DEPTH = 4, WA = 16, AL = 2, TMO = 8;
  localparam int AB = AL * WA;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  sblk_row_sched_if #(.N_ROW(NR), .WID_INST(WI), .WID_ACT(WA), .ACT_LANES(AL)) bus ();
  sblk_row_sched #(
    .N_ROW(NR), .WID_INST(WI), .INST_FIFO_DEPTH(DEPTH),
    .WID_ACT(WA), .ACT_LANES(AL), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [WI-1:0]    q [NR][$];
  int               phase [NR];
  int               waited [NR];
  logic [NR-1:0]    exp_en = '0;
  logic [WI*NR-1:0] exp_idata = '0;
  logic [NR-1:0]    exp_avld = '0;
  logic [AB*NR-1:0] exp_adat = '0;
  logic [NR-1:0]    exp_busy = '0;
  logic             exp_idle = 1'b1;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic inst_rdy_m();
    for (int r = 0; r < NR; r++)
      if (bus.inst_in_mask[r] && q[r].size() >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic act_rdy_m();
    for (int r = 0; r < NR; r++)
      if (bus.act_in_mask[r] && !bus.act_data_in_req[r]) return 1'b0;
    return 1'b1;
  endfunction
  // phase: 0 idle, 1 issuing, 2 waiting for busy rise, 3 waiting for busy fall
  task automatic model_step();
    logic ir, ar;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        q[r].delete();
        phase[r] = 0;
        waited[r] = 0;
      end
      exp_en = '0; exp_idata = '0; exp_avld = '0; exp_adat = '0; exp_busy = '0; exp_idle = 1'b1;
      return;
    end
    ir = inst_rdy_m();
    ar = act_rdy_m();
    for (int r = 0; r < NR; r++) begin
      exp_en[r] = 1'b0;
      if (phase[r] == 0) begin
        if (q[r].size() > 0 && !bus.status_sblk[r]) begin
          phase[r] = 1;
          exp_en[r] = 1'b1;
          exp_idata[r*WI+:WI] = q[r].pop_front();
        end
      end else if (phase[r] == 1) begin
        phase[r] = 2;
        waited[r] = 0;
      end else if (phase[r] == 2) begin
        if (bus.status_sblk[r]) phase[r] = 3;
        else begin
          waited[r]++;
          if (waited[r] == TMO) phase[r] = 0;
        end
      end else if (!bus.status_sblk[r]) phase[r] = 0;
      if (bus.inst_in_vld && ir && bus.inst_in_mask[r]) q[r].push_back(bus.inst_in_data);
      exp_avld[r] = bus.act_in_vld && ar && bus.act_in_mask[r];
      if (exp_avld[r]) exp_adat[r*AB+:AB] = bus.act_in_data;
      exp_busy[r] = phase[r] != 0 || q[r].size() > 0;
    end
    exp_idle = exp_busy == '0;
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_inst_en", 128'(bus.inst_en), 128'(0));
      chk("rst_inst_data", 128'(bus.inst_data), 128'(0));
      chk("rst_act_vld", 128'(bus.act_data_out_vld), 128'(0));
      chk("rst_act_data", 128'(bus.act_data_out), 128'(0));
      chk("rst_row_busy", 128'(bus.row_busy), 128'(0));
      chk("rst_all_idle", 128'(bus.all_idle), 128'(1));
    end else begin
      chk("inst_in_rdy", 128'(bus.inst_in_rdy), 128'(inst_rdy_m()));
      chk("act_in_rdy", 128'(bus.act_in_rdy), 128'(act_rdy_m()));
      chk("inst_en", 128'(bus.inst_en), 128'(exp_en));
      chk("inst_data", 128'(bus.inst_data), 128'(exp_idata));
      chk("act_vld", 128'(bus.act_data_out_vld), 128'(exp_avld));
      chk("act_data", 128'(bus.act_data_out), 128'(exp_adat));
      chk("row_busy", 128'(bus.row_busy), 128'(exp_busy));
      chk("all_idle", 128'(bus.all_idle), 128'(exp_idle));
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    bus.inst_in_data = '0; bus.inst_in_mask = '0; bus.inst_in_vld = 1'b0; bus.status_sblk = '0;
    bus.act_in_data = '0; bus.act_in_mask = '0; bus.act_in_vld = 1'b0; bus.act_data_in_req = '0;
    step(2);
    chk("lit_rst_all_idle", 128'(bus.all_idle), 128'(1));
    chk("lit_rst_inst_en", 128'(bus.inst_en), 128'(0));
    rst = 1'b0;
    step(2);
    // unicast instruction to row 1
    bus.inst_in_mask = 3'b010; bus.inst_in_data = 14'h1A5; bus.inst_in_vld = 1'b1;
    #1 chk("lit_uni_rdy", 128'(bus.inst_in_rdy), 128'(1));
    step();
    bus.inst_in_vld = 1'b0;
    chk("lit_uni_en_t1", 128'(bus.inst_en), 128'(0));
    step();
    chk("lit_uni_en_t2", 128'(bus.inst_en), 128'(3'b010));
    chk("lit_uni_data", 128'(bus.inst_data[WI+:WI]), 128'(14'h1A5));
    step(8);
    chk("lit_tmo_busy", 128'(bus.row_busy), 128'(3'b010));
    step();
    chk("lit_tmo_idle", 128'(bus.row_busy), 128'(0));
    chk("lit_tmo_all_idle", 128'(bus.all_idle), 128'(1));
    // mask 0 is accepted and dropped
    bus.inst_in_mask = 3'b000; bus.inst_in_data = 14'h3FFF; bus.inst_in_vld = 1'b1;
    #1 chk("lit_drop_rdy", 128'(bus.inst_in_rdy), 128'(1));
    step();
    bus.inst_in_vld = 1'b0;
    step(2);
    chk("lit_drop_busy", 128'(bus.row_busy), 128'(0));
    // fill row 0 while its sblk is busy, then broadcast to rows 0 and 1
    bus.status_sblk = 3'b001; bus.inst_in_mask = 3'b001; bus.inst_in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.inst_in_data = 14'h100 + 14'(i);
      step();
    end
    bus.inst_in_mask = 3'b011; bus.inst_in_data = 14'h2B7;
    #1 chk("lit_bc_full_rdy", 128'(bus.inst_in_rdy), 128'(0));
    step();
    chk("lit_bc_no_push", 128'(bus.row_busy), 128'(3'b001));
    bus.status_sblk = 3'b000;
    #1 chk("lit_bc_still_full", 128'(bus.inst_in_rdy), 128'(0));
    step();
    #1 chk("lit_bc_rdy", 128'(bus.inst_in_rdy), 128'(1));
    chk("lit_bc_row0_en", 128'(bus.inst_en), 128'(3'b001));
    chk("lit_bc_row0_data", 128'(bus.inst_data[0+:WI]), 128'(14'h100));
    step();
    bus.inst_in_vld = 1'b0;
    step();
    chk("lit_bc_row1_en", 128'(bus.inst_en), 128'(3'b010));
    chk("lit_bc_row1_data", 128'(bus.inst_data[WI+:WI]), 128'(14'h2B7));
    step(50);
    chk("lit_bc_drained", 128'(bus.all_idle), 128'(1));
    // row 2: busy rises 3 cycles after issue and stays 5 cycles
    bus.inst_in_mask = 3'b100; bus.inst_in_data = 14'h0C1; bus.inst_in_vld = 1'b1;
    step();
    bus.inst_in_data = 14'h0C2;
    step();
    bus.inst_in_vld = 1'b0;
    chk("lit_fsm_en1", 128'(bus.inst_en), 128'(3'b100));
    chk("lit_fsm_data1", 128'(bus.inst_data[2*WI+:WI]), 128'(14'h0C1));
    step(3);
    bus.status_sblk = 3'b100;
    step(5);
    bus.status_sblk = 3'b000;
    chk("lit_fsm_hold", 128'(bus.inst_en), 128'(0));
    step();
    chk("lit_fsm_hold2", 128'(bus.inst_en), 128'(0));
    step();
    chk("lit_fsm_en2", 128'(bus.inst_en), 128'(3'b100));
    chk("lit_fsm_data2", 128'(bus.inst_data[2*WI+:WI]), 128'(14'h0C2));
    step(12);
    chk("lit_fsm_idle", 128'(bus.all_idle), 128'(1));
    // activation broadcast held until every masked row requests
    bus.act_in_mask = 3'b111; bus.act_data_in_req = 3'b101; bus.act_in_data = 32'hCAFE_0001; bus.act_in_vld = 1'b1;
    #1 chk("lit_act_bc_rdy0", 128'(bus.act_in_rdy), 128'(0));
    step();
    chk("lit_act_bc_novld", 128'(bus.act_data_out_vld), 128'(0));
    bus.act_data_in_req = 3'b111;
    #1 chk("lit_act_bc_rdy1", 128'(bus.act_in_rdy), 128'(1));
    step();
    chk("lit_act_bc_vld", 128'(bus.act_data_out_vld), 128'(3'b111));
    for (int r = 0; r < NR; r++)
      chk("lit_act_bc_data", 128'(bus.act_data_out[r*AB+:AB]), 128'(32'hCAFE_0001));
    bus.act_in_mask = 3'b010; bus.act_data_in_req = 3'b010; bus.act_in_data = 32'h1234_5678;
    #1 chk("lit_act_uni_rdy", 128'(bus.act_in_rdy), 128'(1));
    step();
    chk("lit_act_uni_vld", 128'(bus.act_data_out_vld), 128'(3'b010));
    chk("lit_act_uni_data", 128'(bus.act_data_out[AB+:AB]), 128'(32'h1234_5678));
    chk("lit_act_uni_keep", 128'(bus.act_data_out[0+:AB]), 128'(32'hCAFE_0001));
    bus.act_in_mask = 3'b000; bus.act_data_in_req = 3'b000;
    #1 chk("lit_act_drop_rdy", 128'(bus.act_in_rdy), 128'(1));
    step();
    bus.act_in_vld = 1'b0;
    chk("lit_act_drop_vld", 128'(bus.act_data_out_vld), 128'(0));
    step(2);
    // reset while row 2 sits in WAIT_DONE with two entries queued
    bus.inst_in_mask = 3'b100; bus.inst_in_data = 14'h0E1; bus.inst_in_vld = 1'b1;
    step();
    bus.inst_in_data = 14'h0E2;
    step();
    bus.inst_in_data = 14'h0E3;
    bus.status_sblk = 3'b100;
    step();
    bus.inst_in_vld = 1'b0;
    step();
    chk("lit_rm_busy", 128'(bus.row_busy), 128'(3'b100));
    step();
    rst = 1'b1;
    #1;
    chk("lit_rm_en", 128'(bus.inst_en), 128'(0));
    chk("lit_rm_data", 128'(bus.inst_data), 128'(0));
    chk("lit_rm_busy0", 128'(bus.row_busy), 128'(0));
    chk("lit_rm_idle", 128'(bus.all_idle), 128'(1));
    step(2);
    rst = 1'b0;
    bus.status_sblk = 3'b000;
    step();
    chk("lit_rm_idle_after", 128'(bus.all_idle), 128'(1));
    step(12);
    chk("lit_rm_no_issue", 128'(bus.inst_en), 128'(0));
    chk("lit_rm_still_idle", 128'(bus.all_idle), 128'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
